// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter_if
// Description : Bundles the handshakes around the shared-multiplier arbiter:
//               two requester channels (valid/ready plus an operand pair), the
//               response channel (valid/ready, requester id, product) and the
//               launch/result connection to the external multiplier.
//
//               modport slave  : the arbiter side (mult_arbiter).
//               modport master : the environment side (requesters, response
//                                consumer and the multiplier unit).
//
//               Signals
//                 req0_valid/req1_valid   requester has an operand pair pending
//                 req0_a/b, req1_a/b      requester operands, WIDTH bits
//                 req0_ready/req1_ready   request accepted (valid & ready)
//                 rsp_valid/rsp_ready     response handshake
//                 rsp_id                  requester the response belongs to
//                 rsp_data                product, 2*WIDTH bits
//                 unit_a/unit_b           multiplier operands
//                 unit_start              single-cycle launch strobe
//                 unit_result             multiplier output, 2*WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_arbiter_if #(
    parameter int WIDTH = 6
);
    logic                   req0_valid;
    logic [WIDTH-1:0]       req0_a;
    logic [WIDTH-1:0]       req0_b;
    logic                   req0_ready;

    logic                   req1_valid;
    logic [WIDTH-1:0]       req1_a;
    logic [WIDTH-1:0]       req1_b;
    logic                   req1_ready;

    logic                   rsp_valid;
    logic                   rsp_id;
    logic [2*WIDTH-1:0]     rsp_data;
    logic                   rsp_ready;

    logic [WIDTH-1:0]       unit_a;
    logic [WIDTH-1:0]       unit_b;
    logic                   unit_start;
    logic [2*WIDTH-1:0]     unit_result;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready,
        output unit_a, unit_b, unit_start,
        input  unit_result
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready,
        input  unit_a, unit_b, unit_start,
        output unit_result
    );
endinterface : mult_arbiter_if
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter sharing one external multiplier between
//               two requesters. One operation is in flight at a time:
//                 IDLE - pick a requester, latch its operands, go to EXEC
//                 EXEC - drive the multiplier for LATENCY cycles, pulse
//                        unit_start on the first one, capture the result on
//                        the last one
//                 RESP - present the product until the consumer takes it
//               A full operation takes LATENCY+2 cycles including the IDLE
//               cycle in which the request is accepted.
//
// Parameters  : WIDTH   - operand width in bits (product is 2*WIDTH)
//               LATENCY - cycles from unit_start until unit_result is taken,
//                         legal range 1..15
// Ports       : clk     - clock, all state updates on the rising edge
//               reset   - synchronous, active-high; aborts any operation
//               enable  - low freezes every register; ready and unit_start
//                         are forced low while frozen
//               bus     - mult_arbiter_if.slave (requests, response, unit)
//               busy    - high whenever the FSM is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int WIDTH   = 6,
    parameter int LATENCY = 2
) (
    input  wire             clk,
    input  wire             reset,
    input  wire             enable,
    mult_arbiter_if.slave   bus,
    output logic            busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Counter is sized for the largest legal LATENCY (15).
    localparam logic [3:0] c_LAT  = 4'(LATENCY);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]             state_q,      state_d;
    logic [3:0]             cnt_q,        cnt_d;
    logic [WIDTH-1:0]       op_a_q,       op_a_d;
    logic [WIDTH-1:0]       op_b_q,       op_b_d;
    logic                   rsp_id_q,     rsp_id_d;
    logic [2*WIDTH-1:0]     rsp_data_q,   rsp_data_d;
    logic                   last_grant_q, last_grant_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // With both requesters pending the one that did not win last time gets
    // the grant; a lone requester always wins. w_grant is only meaningful
    // while w_any is high.
    // ------------------------------------------------------------------------
    logic w_any;
    logic w_grant;
    logic w_accept;

    assign w_any    = bus.req0_valid | bus.req1_valid;
    assign w_grant  = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q
                                                        : bus.req1_valid;
    assign w_accept = enable & (state_q == c_IDLE) & w_any;

    // ------------------------------------------------------------------------
    // Process 1: state register
    // Reset wins over enable; otherwise nothing moves while enable is low.
    // last_grant resets to 1 so requester 0 wins the first contention.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= c_IDLE;
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            last_grant_q <= 1'b1;
        end else if (enable) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state and datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        last_grant_d = last_grant_q;

        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    // Operands are copied here so later changes on the
                    // request lines cannot affect the running operation.
                    op_a_d       = w_grant ? bus.req1_a : bus.req0_a;
                    op_b_d       = w_grant ? bus.req1_b : bus.req0_b;
                    rsp_id_d     = w_grant;
                    last_grant_d = w_grant;
                    cnt_d        = c_LAT;
                    state_d      = c_EXEC;
                end
            end

            c_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                // A count of 1 marks the last EXEC cycle, so EXEC lasts
                // exactly LATENCY enabled cycles.
                if (cnt_q == 4'd1) begin
                    rsp_data_d = bus.unit_result;
                    state_d    = c_RESP;
                end
            end

            c_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = c_IDLE;
                end
            end

            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.unit_a     = '0;
        bus.unit_b     = '0;
        bus.unit_start = 1'b0;
        bus.rsp_valid  = (state_q == c_RESP);
        bus.rsp_id     = rsp_id_q;
        bus.rsp_data   = rsp_data_q;
        busy           = (state_q != c_IDLE);

        if (w_accept) begin
            bus.req0_ready = ~w_grant;
            bus.req1_ready =  w_grant;
        end

        if (state_q == c_EXEC) begin
            bus.unit_a     = op_a_q;
            bus.unit_b     = op_b_q;
            // The counter still holds its load value only in the first EXEC
            // cycle; if that cycle is frozen the strobe waits for enable.
            bus.unit_start = enable & (cnt_q == c_LAT);
        end
    end

endmodule : mult_arbiter
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter. Two instances: one with
//               LATENCY=2 driving a registered multiplier model, one with
//               LATENCY=1 driving a combinational multiplier model. Stimulus
//               pushes the expected {id, product} of every accepted request
//               into a per-instance queue; a monitor per instance pops and
//               compares on every completed response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic busy2;
    logic busy1;

    always #5 clk = ~clk;

    mult_arbiter_if #(.WIDTH(6)) i2 ();
    mult_arbiter_if #(.WIDTH(6)) i1 ();

    mult_arbiter #(.WIDTH(6), .LATENCY(2)) u_dut2 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (i2.slave),
        .busy   (busy2)
    );

    mult_arbiter #(.WIDTH(6), .LATENCY(1)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (i1.slave),
        .busy   (busy1)
    );

    // Multiplier models: registered for LATENCY=2, combinational for 1.
    logic [11:0] prod2 = '0;
    always @(posedge clk) if (i2.unit_start) prod2 <= 12'(i2.unit_a) * 12'(i2.unit_b);
    assign i2.unit_result = prod2;
    assign i1.unit_result = 12'(i1.unit_a) * 12'(i1.unit_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [12:0] q2[$];
    logic [12:0] q1[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur within cycle budget (cycle %0d)", nm, cyc);
    endtask

    // nx: move into the next cycle and drive; md: mid-cycle sample point.
    task automatic nx();
        @(posedge clk);
        #2;
    endtask

    task automatic md();
        @(negedge clk);
    endtask

    task automatic drain2();
        int t;
        t = 0;
        md();
        while (busy2 && t < 20) begin
            nx();
            md();
            t++;
        end
        if (busy2) tmo("drain2");
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        logic [12:0] e;
        if (!reset && enable && i2.rsp_valid && i2.rsp_ready) begin
            if (q2.size() == 0) begin
                tmo("rsp2_unexpected");
            end else begin
                e = q2.pop_front();
                check("rsp2_id",   32'(i2.rsp_id),   32'(e[12]));
                check("rsp2_data", 32'(i2.rsp_data), 32'(e[11:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [12:0] e;
        if (!reset && enable && i1.rsp_valid && i1.rsp_ready) begin
            if (q1.size() == 0) begin
                tmo("rsp1_unexpected");
            end else begin
                e = q1.pop_front();
                check("rsp1_id",   32'(i1.rsp_id),   32'(e[12]));
                check("rsp1_data", 32'(i1.rsp_data), 32'(e[11:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout");
        $fatal(1, "watchdog");
    end

    int gseq[4] = '{0, 1, 0, 1};

    initial begin
        int last_acc;
        last_acc = 0;
        reset  = 1'b1;
        enable = 1'b1;
        i2.req0_valid = 0; i2.req0_a = 0; i2.req0_b = 0;
        i2.req1_valid = 0; i2.req1_a = 0; i2.req1_b = 0;
        i2.rsp_ready  = 1;
        i1.req0_valid = 0; i1.req0_a = 0; i1.req0_b = 0;
        i1.req1_valid = 0; i1.req1_a = 0; i1.req1_b = 0;
        i1.rsp_ready  = 1;

        // ---------------- reset state ----------------
        nx(); nx(); md();
        check("rst_busy",       32'(busy2),          0);
        check("rst_rsp_valid",  32'(i2.rsp_valid),   0);
        check("rst_unit_start", 32'(i2.unit_start),  0);
        check("rst_rsp_data",   32'(i2.rsp_data),    0);
        check("rst_rsp_id",     32'(i2.rsp_id),      0);
        check("rst_unit_a",     32'(i2.unit_a),      0);
        check("rst_busy1",      32'(busy1),          0);

        // ---------------- contention: grants 0,1,0,1 ----------------
        nx();
        reset = 1'b0;
        i2.req0_valid = 1; i2.req0_a = 3;  i2.req0_b = 4;
        i2.req1_valid = 1; i2.req1_a = 63; i2.req1_b = 63;
        for (int k = 0; k < 4; k++) begin
            int t;
            bit found;
            t = 0;
            found = 0;
            md();
            while (!found && t < 12) begin
                if (i2.req0_ready || i2.req1_ready) found = 1;
                else begin nx(); md(); t++; end
            end
            if (!found) begin
                tmo("cont_grant");
            end else begin
                check("cont_grant_id", 32'(i2.req1_ready), 32'(gseq[k]));
                check("cont_onehot",   32'(i2.req0_ready ^ i2.req1_ready), 1);
                if (k > 0) check("cont_turnaround", 32'(cyc - last_acc), 4);
                last_acc = cyc;
                q2.push_back((gseq[k] != 0) ? {1'b1, 12'd3969} : {1'b0, 12'd12});
            end
            nx();
        end
        i2.req0_valid = 0;
        i2.req1_valid = 0;
        drain2();

        // ---------------- single op, operands changed after accept ----------------
        nx();
        i2.req0_valid = 1; i2.req0_a = 5; i2.req0_b = 7;
        md();
        check("s_rdy0", 32'(i2.req0_ready), 1);
        check("s_rdy1", 32'(i2.req1_ready), 0);
        q2.push_back({1'b0, 12'd35});
        nx();
        i2.req0_valid = 0; i2.req0_a = 9; i2.req0_b = 9;
        md();
        check("s_start",    32'(i2.unit_start), 1);
        check("s_unit_a",   32'(i2.unit_a),     5);
        check("s_unit_b",   32'(i2.unit_b),     7);
        check("s_busy",     32'(busy2),         1);
        nx(); md();
        check("s_start_once", 32'(i2.unit_start), 0);
        check("s_unit_a_hold", 32'(i2.unit_a),    5);
        check("s_valid_early", 32'(i2.rsp_valid), 0);
        nx(); md();
        check("s_rsp_valid", 32'(i2.rsp_valid), 1);
        check("s_unit_a_resp", 32'(i2.unit_a),  0);
        nx(); md();
        check("s_valid_after", 32'(i2.rsp_valid), 0);
        check("s_busy_after",  32'(busy2),        0);

        // ---------------- backpressure ----------------
        nx();
        i2.rsp_ready = 0;
        i2.req1_valid = 1; i2.req1_a = 10; i2.req1_b = 20;
        md();
        check("bp_rdy1", 32'(i2.req1_ready), 1);
        q2.push_back({1'b1, 12'd200});
        nx();
        i2.req1_valid = 0;
        i2.req0_valid = 1; i2.req0_a = 2; i2.req0_b = 3;
        md();
        check("bp_no_rdy_exec", 32'(i2.req0_ready), 0);
        nx(); nx(); md();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(i2.rsp_valid),  1);
            check("bp_data",  32'(i2.rsp_data),   200);
            check("bp_id",    32'(i2.rsp_id),     1);
            check("bp_busy",  32'(busy2),         1);
            check("bp_rdy0",  32'(i2.req0_ready), 0);
            nx(); md();
        end
        nx();
        i2.rsp_ready = 1;
        md();
        check("bp_release_valid", 32'(i2.rsp_valid), 1);
        nx(); md();
        check("bp_done_valid", 32'(i2.rsp_valid),  0);
        check("bp_next_rdy0",  32'(i2.req0_ready), 1);
        q2.push_back({1'b0, 12'd6});
        nx();
        i2.req0_valid = 0;
        drain2();

        // ---------------- enable low mid-EXEC, then in RESP ----------------
        nx();
        i2.req0_valid = 1; i2.req0_a = 6; i2.req0_b = 7;
        md();
        check("en_rdy0", 32'(i2.req0_ready), 1);
        q2.push_back({1'b0, 12'd42});
        nx();
        i2.req0_valid = 0;
        md();
        check("en_start", 32'(i2.unit_start), 1);
        nx();
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            md();
            check("en_frz_start", 32'(i2.unit_start), 0);
            check("en_frz_valid", 32'(i2.rsp_valid),  0);
            check("en_frz_busy",  32'(busy2),         1);
            check("en_frz_unit_a", 32'(i2.unit_a),    6);
            nx();
        end
        enable = 1;
        md();
        check("en_still_exec", 32'(i2.rsp_valid), 0);
        nx();
        enable = 0;
        md();
        check("en_rsp_delayed", 32'(i2.rsp_valid), 1);
        nx();
        enable = 1;
        md();
        check("en_rsp_held", 32'(i2.rsp_valid), 1);
        nx(); md();
        check("en_rsp_gone", 32'(i2.rsp_valid), 0);

        // ---------------- reset during RESP ----------------
        nx();
        i2.rsp_ready = 0;
        i2.req0_valid = 1; i2.req0_a = 5; i2.req0_b = 5;
        md();
        check("rr_rdy0", 32'(i2.req0_ready), 1);
        nx();
        i2.req0_valid = 0;
        nx(); nx(); md();
        check("rr_in_resp", 32'(i2.rsp_valid), 1);
        nx();
        reset = 1;
        nx();
        reset = 0;
        i2.rsp_ready = 1;
        i2.req0_valid = 1; i2.req0_a = 4; i2.req0_b = 4;
        i2.req1_valid = 1; i2.req1_a = 1; i2.req1_b = 2;
        md();
        check("rr_valid", 32'(i2.rsp_valid),  0);
        check("rr_busy",  32'(busy2),         0);
        check("rr_rdy0",  32'(i2.req0_ready), 1);
        check("rr_rdy1",  32'(i2.req1_ready), 0);
        q2.push_back({1'b0, 12'd16});
        nx();
        i2.req0_valid = 0;
        i2.req1_valid = 0;
        drain2();

        // ---------------- LATENCY=1 instance ----------------
        nx();
        i1.req1_valid = 1; i1.req1_a = 0; i1.req1_b = 42;
        md();
        check("l1_rdy1", 32'(i1.req1_ready), 1);
        q1.push_back({1'b1, 12'd0});
        nx();
        i1.req1_valid = 0;
        md();
        check("l1_start", 32'(i1.unit_start), 1);
        check("l1_valid_early", 32'(i1.rsp_valid), 0);
        nx(); md();
        check("l1_valid", 32'(i1.rsp_valid), 1);
        nx();
        i1.req0_valid = 1; i1.req0_a = 7; i1.req0_b = 9;
        md();
        check("l1_rdy0", 32'(i1.req0_ready), 1);
        q1.push_back({1'b0, 12'd63});
        nx();
        i1.req0_valid = 0;
        nx(); md();
        check("l1_valid2", 32'(i1.rsp_valid), 1);
        nx(); md();
        check("l1_valid2_gone", 32'(i1.rsp_valid), 0);

        // ---------------- all expected responses consumed ----------------
        nx(); nx(); md();
        check("q2_empty", 32'(q2.size()), 0);
        check("q1_empty", 32'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mult_arbiter
`default_nettype wire
